// File: rtl/mem_arbiter_if.sv
// Requester handshakes, responses and memory strobes around mem_arbiter.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface mem_arbiter_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        if_rsp_error;

  logic        ls_req_valid;
  logic        ls_req_ready;
  logic        ls_req_write;
  logic [31:0] ls_req_addr;
  logic [31:0] ls_req_wdata;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;
  logic        ls_rsp_error;

  logic        mem_read_enable;
  logic [31:0] mem_read_address;
  logic [31:0] mem_read_value;
  logic        mem_write_enable;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_value;

  logic        busy;

  modport slave (
    input  if_req_valid, if_req_addr,
    input  ls_req_valid, ls_req_write, ls_req_addr, ls_req_wdata,
    input  mem_read_value,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_error,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_error,
    output mem_read_enable, mem_read_address,
    output mem_write_enable, mem_write_address, mem_write_value,
    output busy
  );

  modport master (
    output if_req_valid, if_req_addr,
    output ls_req_valid, ls_req_write, ls_req_addr, ls_req_wdata,
    output mem_read_value,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_error,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_error,
    input  mem_read_enable, mem_read_address,
    input  mem_write_enable, mem_write_address, mem_write_value,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter for a single-port word memory with
// registered read/write strobes, one transaction in flight, starvation guard for IF.
module mem_arbiter #(
  parameter int MEMORY_SIZE  = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clock,
  input logic          reset_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [3:0]  LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [31:0] MEM_WORDS = 32'(MEMORY_SIZE);

  state_e      state_q;
  logic        owner_ls_q;
  logic        write_q;
  logic [3:0]  starve_q, starve_d;

  logic        mem_re_q, mem_we_q;
  logic [31:0] mem_raddr_q, mem_waddr_q, mem_wdata_q;

  logic        if_rsp_valid_q, if_rsp_error_q;
  logic [31:0] if_rsp_data_q;
  logic        ls_rsp_valid_q, ls_rsp_error_q;
  logic [31:0] ls_rsp_data_q;

  logic        if_ready, ls_ready, if_accept, ls_accept, req_write, req_err;
  logic [31:0] req_addr;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    if_ready = 1'b0;
    ls_ready = 1'b0;
    if (reset_n && state_q == IDLE) begin
      if (starve_q == LIMIT) begin
        if_ready = 1'b1;
        ls_ready = !bus.if_req_valid;
      end else begin
        ls_ready = 1'b1;
        if_ready = !bus.ls_req_valid;
      end
    end
    if_accept = if_ready & bus.if_req_valid;
    ls_accept = ls_ready & bus.ls_req_valid;
    req_addr  = ls_accept ? bus.ls_req_addr : bus.if_req_addr;
    req_write = ls_accept & bus.ls_req_write;
    req_err   = (req_addr >= MEM_WORDS);

    starve_d = starve_q;
    if (if_accept)
      starve_d = '0;
    else if (ls_accept && bus.if_req_valid && starve_q != LIMIT)
      starve_d = starve_q + 4'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and updates together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      owner_ls_q     <= 1'b0;
      write_q        <= 1'b0;
      starve_q       <= '0;
      mem_re_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_raddr_q    <= '0;
      mem_waddr_q    <= '0;
      mem_wdata_q    <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_error_q <= 1'b0;
      if_rsp_data_q  <= '0;
      ls_rsp_valid_q <= 1'b0;
      ls_rsp_error_q <= 1'b0;
      ls_rsp_data_q  <= '0;
    end else begin
      // Strobes last exactly one cycle; addresses, data and response fields hold.
      mem_re_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      starve_q       <= starve_d;

      case (state_q)
        IDLE: begin
          if (if_accept || ls_accept) begin
            owner_ls_q <= ls_accept;
            write_q    <= req_write;
            if (req_err) begin
              state_q <= RESP;
              if (ls_accept) begin
                ls_rsp_valid_q <= 1'b1;
                ls_rsp_data_q  <= '0;
                ls_rsp_error_q <= 1'b1;
              end else begin
                if_rsp_valid_q <= 1'b1;
                if_rsp_data_q  <= '0;
                if_rsp_error_q <= 1'b1;
              end
            end else begin
              state_q <= ISSUE;
              if (req_write) begin
                mem_we_q    <= 1'b1;
                mem_waddr_q <= req_addr;
                mem_wdata_q <= bus.ls_req_wdata;
              end else begin
                mem_re_q    <= 1'b1;
                mem_raddr_q <= req_addr;
              end
            end
          end
        end
        ISSUE: begin
          if (write_q) begin
            // Only the LS port can store, so the ack always goes there.
            state_q        <= RESP;
            ls_rsp_valid_q <= 1'b1;
            ls_rsp_data_q  <= '0;
            ls_rsp_error_q <= 1'b0;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          state_q <= RESP;
          if (owner_ls_q) begin
            ls_rsp_valid_q <= 1'b1;
            ls_rsp_data_q  <= bus.mem_read_value;
            ls_rsp_error_q <= 1'b0;
          end else begin
            if_rsp_valid_q <= 1'b1;
            if_rsp_data_q  <= bus.mem_read_value;
            if_rsp_error_q <= 1'b0;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.if_req_ready      = if_ready;
  assign bus.ls_req_ready      = ls_ready;
  assign bus.if_rsp_valid      = if_rsp_valid_q;
  assign bus.if_rsp_data       = if_rsp_data_q;
  assign bus.if_rsp_error      = if_rsp_error_q;
  assign bus.ls_rsp_valid      = ls_rsp_valid_q;
  assign bus.ls_rsp_data       = ls_rsp_data_q;
  assign bus.ls_rsp_error      = ls_rsp_error_q;
  assign bus.mem_read_enable   = mem_re_q;
  assign bus.mem_read_address  = mem_raddr_q;
  assign bus.mem_write_enable  = mem_we_q;
  assign bus.mem_write_address = mem_waddr_q;
  assign bus.mem_write_value   = mem_wdata_q;
  assign bus.busy              = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model with a
// per-cycle compare process, directed scenarios with literal expectations, random traffic.
module tb_mem_arbiter;

  localparam int MEM_SIZE = 1024;
  localparam int LIMIT    = 4;

  typedef struct {
    logic        is_ls;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mem_arbiter_if bus();

  mem_arbiter #(.MEMORY_SIZE(MEM_SIZE), .STARVE_LIMIT(LIMIT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %h, want %h", name, cyc, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  function automatic logic [31:0] preload(input int i);
    if (i == 10) return 32'h0000_0013;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  // Memory behind the arbiter: registered read, write on strobe.
  logic [31:0] mem [0:MEM_SIZE-1];
  logic        mem_loaded = 1'b0;
  always @(posedge clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= preload(i);
      mem_loaded <= 1'b1;
    end else begin
      if (bus.mem_write_enable) mem[bus.mem_write_address[9:0]] <= bus.mem_write_value;
      if (bus.mem_read_enable)  bus.mem_read_value <= mem[bus.mem_read_address[9:0]];
    end
  end

  // Reference model: schedule of expected events keyed by cycle number.
  logic [31:0] model_mem [0:MEM_SIZE-1];
  logic        model_loaded = 1'b0;
  rsp_t        exp_rsp [int];
  logic [31:0] exp_rd  [int];
  logic [63:0] exp_wr  [int];
  int          idle_from = 0;
  int          starve = 0;

  always @(negedge clock) begin
    logic        idle, e_if_rdy, e_ls_rdy, acc_if, acc_ls, wr, err;
    logic [31:0] a, wd, ra;
    logic [63:0] w;
    rsp_t        r;
    int          lat;
    cyc++;
    if (!model_loaded) begin
      for (int i = 0; i < MEM_SIZE; i++) model_mem[i] = preload(i);
      model_loaded = 1'b1;
    end
    if (!reset_n) begin
      chk1("rst if_req_ready", bus.if_req_ready, 1'b0);
      chk1("rst ls_req_ready", bus.ls_req_ready, 1'b0);
      chk1("rst busy", bus.busy, 1'b0);
      chk1("rst if_rsp_valid", bus.if_rsp_valid, 1'b0);
      chk1("rst ls_rsp_valid", bus.ls_rsp_valid, 1'b0);
      chk1("rst if_rsp_error", bus.if_rsp_error, 1'b0);
      chk1("rst ls_rsp_error", bus.ls_rsp_error, 1'b0);
      check("rst if_rsp_data", bus.if_rsp_data, 32'd0);
      check("rst ls_rsp_data", bus.ls_rsp_data, 32'd0);
      chk1("rst mem_read_enable", bus.mem_read_enable, 1'b0);
      chk1("rst mem_write_enable", bus.mem_write_enable, 1'b0);
      check("rst mem_read_address", bus.mem_read_address, 32'd0);
      check("rst mem_write_address", bus.mem_write_address, 32'd0);
      check("rst mem_write_value", bus.mem_write_value, 32'd0);
      exp_rsp.delete();
      exp_rd.delete();
      exp_wr.delete();
      starve    = 0;
      idle_from = cyc + 1;
    end else begin
      idle     = (cyc >= idle_from);
      e_if_rdy = 1'b0;
      e_ls_rdy = 1'b0;
      if (idle) begin
        if (starve == LIMIT) begin
          e_if_rdy = 1'b1;
          e_ls_rdy = !bus.if_req_valid;
        end else begin
          e_ls_rdy = 1'b1;
          e_if_rdy = !bus.ls_req_valid;
        end
      end
      chk1("if_req_ready", bus.if_req_ready, e_if_rdy);
      chk1("ls_req_ready", bus.ls_req_ready, e_ls_rdy);
      chk1("busy", bus.busy, !idle);

      chk1("mem_read_enable", bus.mem_read_enable, exp_rd.exists(cyc));
      if (exp_rd.exists(cyc)) begin
        ra = exp_rd[cyc];
        check("mem_read_address", bus.mem_read_address, ra);
        exp_rd.delete(cyc);
      end
      chk1("mem_write_enable", bus.mem_write_enable, exp_wr.exists(cyc));
      if (exp_wr.exists(cyc)) begin
        w = exp_wr[cyc];
        check("mem_write_address", bus.mem_write_address, w[63:32]);
        check("mem_write_value", bus.mem_write_value, w[31:0]);
        exp_wr.delete(cyc);
      end

      if (exp_rsp.exists(cyc)) begin
        r = exp_rsp[cyc];
        chk1("if_rsp_valid", bus.if_rsp_valid, !r.is_ls);
        chk1("ls_rsp_valid", bus.ls_rsp_valid, r.is_ls);
        if (r.is_ls) begin
          check("ls_rsp_data", bus.ls_rsp_data, r.data);
          chk1("ls_rsp_error", bus.ls_rsp_error, r.err);
        end else begin
          check("if_rsp_data", bus.if_rsp_data, r.data);
          chk1("if_rsp_error", bus.if_rsp_error, r.err);
        end
        exp_rsp.delete(cyc);
      end else begin
        chk1("if_rsp_valid", bus.if_rsp_valid, 1'b0);
        chk1("ls_rsp_valid", bus.ls_rsp_valid, 1'b0);
      end

      // Decide what the edge ending this cycle accepts.
      if (idle) begin
        acc_if = bus.if_req_valid && e_if_rdy;
        acc_ls = bus.ls_req_valid && e_ls_rdy;
        if (acc_if || acc_ls) begin
          a   = acc_ls ? bus.ls_req_addr : bus.if_req_addr;
          wr  = acc_ls && bus.ls_req_write;
          wd  = bus.ls_req_wdata;
          err = (a >= 32'(MEM_SIZE));
          r.is_ls = acc_ls;
          r.err   = err;
          r.data  = 32'd0;
          if (err) lat = 1;
          else if (wr) begin
            lat = 2;
            exp_wr[cyc + 1] = {a, wd};
            model_mem[a[9:0]] = wd;
          end else begin
            lat = 3;
            exp_rd[cyc + 1] = a;
            r.data = model_mem[a[9:0]];
          end
          exp_rsp[cyc + lat] = r;
          idle_from = cyc + lat + 1;
        end
        if (acc_if) starve = 0;
        else if (acc_ls && bus.if_req_valid && starve < LIMIT) starve++;
      end
    end
  end

  // Issues one request and measures strobe/response cycles relative to the accept edge.
  task automatic run_txn(input logic use_ls, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, output int rsp_lat, output int rd_at,
                         output int wr_at, output logic [31:0] data, output logic err);
    int   n;
    logic accepted;
    rsp_lat = -1; rd_at = 0; wr_at = 0; data = '0; err = 1'b0;
    @(posedge clock); #1;
    if (use_ls) begin
      bus.ls_req_valid = 1'b1; bus.ls_req_write = wr;
      bus.ls_req_addr  = addr; bus.ls_req_wdata = wdata;
    end else begin
      bus.if_req_valid = 1'b1; bus.if_req_addr = addr;
    end
    n = 0;
    accepted = 1'b0;
    while (!accepted && n < 20) begin
      @(negedge clock);
      n++;
      accepted = use_ls ? bus.ls_req_ready : bus.if_req_ready;
    end
    @(posedge clock); #1;
    bus.ls_req_valid = 1'b0;
    bus.if_req_valid = 1'b0;
    if (accepted) begin
      for (int k = 1; k <= 8; k++) begin
        @(negedge clock);
        if (bus.mem_read_enable  && rd_at == 0) rd_at = k;
        if (bus.mem_write_enable && wr_at == 0) wr_at = k;
        if (use_ls ? bus.ls_rsp_valid : bus.if_rsp_valid) begin
          rsp_lat = k;
          data = use_ls ? bus.ls_rsp_data  : bus.if_rsp_data;
          err  = use_ls ? bus.ls_rsp_error : bus.if_rsp_error;
          break;
        end
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'(MEM_SIZE) + 32'($urandom_range(0, 3));
    if (r == 1) return $urandom;
    return 32'($urandom_range(0, MEM_SIZE - 1));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat, rd_at, wr_at, n, k_if, k_ls, cnt;
    logic [31:0] d;
    logic        e, if_acc, ls_acc, seen;
    logic [9:0]  seq;

    bus.if_req_valid = 1'b0; bus.if_req_addr  = '0;
    bus.ls_req_valid = 1'b0; bus.ls_req_write = 1'b0;
    bus.ls_req_addr  = '0;   bus.ls_req_wdata = '0;

    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // Store then load at word 5.
    run_txn(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, lat, rd_at, wr_at, d, e);
    check("store ack latency", 32'(lat), 32'd2);
    check("store write strobe cycle", 32'(wr_at), 32'd1);
    check("store read strobe absent", 32'(rd_at), 32'd0);
    chk1("store error", e, 1'b0);
    check("memory word 5 after store", mem[5], 32'hDEAD_BEEF);
    run_txn(1'b1, 1'b0, 32'd5, 32'd0, lat, rd_at, wr_at, d, e);
    check("load latency", 32'(lat), 32'd3);
    check("load read strobe cycle", 32'(rd_at), 32'd1);
    check("load data", d, 32'hDEAD_BEEF);
    chk1("load error", e, 1'b0);

    // Fetch of preloaded word 10.
    run_txn(1'b0, 1'b0, 32'd10, 32'd0, lat, rd_at, wr_at, d, e);
    check("fetch latency", 32'(lat), 32'd3);
    check("fetch read strobe cycle", 32'(rd_at), 32'd1);
    check("fetch data", d, 32'h0000_0013);

    // Simultaneous IF and LS with counter at 0: LS first, IF next.
    @(posedge clock); #1;
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'd1;
    bus.ls_req_valid = 1'b1; bus.ls_req_write = 1'b0; bus.ls_req_addr = 32'd2;
    k_if = 0; k_ls = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if_acc = bus.if_req_valid && bus.if_req_ready;
      ls_acc = bus.ls_req_valid && bus.ls_req_ready;
      if (bus.if_rsp_valid && k_if == 0) k_if = k;
      if (bus.ls_rsp_valid && k_ls == 0) k_ls = k;
      if (k_if != 0 && k_ls != 0) break;
      @(posedge clock); #1;
      if (if_acc) bus.if_req_valid = 1'b0;
      if (ls_acc) bus.ls_req_valid = 1'b0;
    end
    @(posedge clock); #1;
    bus.if_req_valid = 1'b0; bus.ls_req_valid = 1'b0;
    check("simultaneous LS response cycle", 32'(k_ls), 32'd4);
    check("simultaneous IF response cycle", 32'(k_if), 32'd8);

    // Starvation: both held valid, winners LLLLI repeated.
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'd4;
    bus.ls_req_valid = 1'b1; bus.ls_req_write = 1'b0; bus.ls_req_addr = 32'd3;
    seq = '0; cnt = 0;
    for (int k = 0; k < 200 && cnt < 10; k++) begin
      @(negedge clock);
      if (bus.if_rsp_valid) begin seq = {seq[8:0], 1'b0}; cnt++; end
      if (bus.ls_rsp_valid) begin seq = {seq[8:0], 1'b1}; cnt++; end
    end
    @(posedge clock); #1;
    bus.if_req_valid = 1'b0; bus.ls_req_valid = 1'b0;
    check("starvation response count", 32'(cnt), 32'd10);
    check("starvation winner order", {22'd0, seq}, {22'd0, 10'b11110_11110});

    // Out-of-range load and store.
    run_txn(1'b1, 1'b0, 32'd1024, 32'd0, lat, rd_at, wr_at, d, e);
    check("oob load latency", 32'(lat), 32'd1);
    chk1("oob load error", e, 1'b1);
    check("oob load data", d, 32'd0);
    check("oob load read strobe", 32'(rd_at), 32'd0);
    check("oob load write strobe", 32'(wr_at), 32'd0);
    run_txn(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, lat, rd_at, wr_at, d, e);
    check("oob store latency", 32'(lat), 32'd1);
    chk1("oob store error", e, 1'b1);
    check("oob store write strobe", 32'(wr_at), 32'd0);

    // Reset while a fetch is in WAIT.
    @(posedge clock); #1;
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'd7;
    n = 0;
    do begin @(negedge clock); n++; end while (!bus.if_req_ready && n < 20);
    @(posedge clock); #1;
    bus.if_req_valid = 1'b0;
    @(posedge clock); #1;
    chk1("busy in WAIT", bus.busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("reset mid-read busy", bus.busy, 1'b0);
    chk1("reset mid-read read strobe", bus.mem_read_enable, 1'b0);
    check("reset mid-read read address", bus.mem_read_address, 32'd0);
    chk1("reset mid-read if_rsp_valid", bus.if_rsp_valid, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (bus.if_rsp_valid || bus.ls_rsp_valid) seen = 1'b1;
    end
    chk1("no response after reset", seen, 1'b0);
    run_txn(1'b1, 1'b0, 32'd5, 32'd0, lat, rd_at, wr_at, d, e);
    check("post-reset load latency", 32'(lat), 32'd3);
    check("post-reset load data", d, 32'hDEAD_BEEF);

    // Random traffic against the model, including withdrawals and bad addresses.
    for (int n_cyc = 0; n_cyc < 3000; n_cyc++) begin
      @(negedge clock);
      if_acc = bus.if_req_valid && bus.if_req_ready;
      ls_acc = bus.ls_req_valid && bus.ls_req_ready;
      @(posedge clock); #1;
      if (!bus.if_req_valid || if_acc) begin
        bus.if_req_valid = ($urandom_range(0, 2) != 0);
        bus.if_req_addr  = rand_addr();
      end else if ($urandom_range(0, 15) == 0) begin
        bus.if_req_valid = 1'b0;
      end
      if (!bus.ls_req_valid || ls_acc) begin
        bus.ls_req_valid = ($urandom_range(0, 2) != 0);
        bus.ls_req_write = $urandom_range(0, 1) == 1;
        bus.ls_req_addr  = rand_addr();
        bus.ls_req_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        bus.ls_req_valid = 1'b0;
      end
    end
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;
    repeat (10) @(posedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
